// File: rtl/card_pkg.sv
// Shared card codes and 7-segment glyphs (active-low, bit order {g,f,e,d,c,b,a}).
package card_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] card_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_ACE   = 4'd1;
    localparam card_t CARD_JACK  = 4'd11;
    localparam card_t CARD_QUEEN = 4'd12;
    localparam card_t CARD_KING  = 4'd13;

    localparam seg_t SEG_EMPTY = 7'b1111111;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_10    = 7'b1000000;
    localparam seg_t SEG_J     = 7'b1100001;
    localparam seg_t SEG_Q     = 7'b0011000;
    localparam seg_t SEG_K     = 7'b0001001;

endpackage

// File: rtl/card_7seg_decode.sv
// Combinational card-code to active-low glyph lookup.
module card_7seg_decode
    import card_pkg::*;
(
    input  logic [3:0] card,
    output logic [6:0] seg
);

    // Plain case with default: unknown or unused codes resolve to a blank glyph.
    always_comb begin
        seg = SEG_EMPTY;
        case (card)
            CARD_EMPTY: seg = SEG_EMPTY;
            CARD_ACE:   seg = SEG_A;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            4'd10:      seg = SEG_10;
            CARD_JACK:  seg = SEG_J;
            CARD_QUEEN: seg = SEG_Q;
            CARD_KING:  seg = SEG_K;
            default:    seg = SEG_EMPTY;
        endcase
    end

endmodule

// File: rtl/card_7seg.sv
// Registered card glyph driver for one HEX display, with selectable segment polarity.
module card_7seg
    import card_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] card,
    output logic [6:0] HEX
);

    localparam seg_t BLANK = ACTIVE_LOW ? SEG_EMPTY : ~SEG_EMPTY;

    logic [6:0] glyph;
    logic [6:0] drive;

    card_7seg_decode u_decode (
        .card (card),
        .seg  (glyph)
    );

    assign drive = ACTIVE_LOW ? glyph : ~glyph;

    always_ff @(posedge clk) begin
        if (rst) begin
            HEX <= BLANK;
        end else begin
            HEX <= drive;
        end
    end

endmodule

// File: tb/tb_card_7seg.sv
// Directed bench for card_7seg: both polarities share clock, reset and card input.
module tb_card_7seg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] card = 4'd0;
    logic [6:0] hex_lo;
    logic [6:0] hex_hi;

    int unsigned checks = 0;
    int unsigned passed = 0;

    logic [6:0] table_lo [16];

    card_7seg #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk  (clk),
        .rst  (rst),
        .card (card),
        .HEX  (hex_lo)
    );

    card_7seg #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk  (clk),
        .rst  (rst),
        .card (card),
        .HEX  (hex_hi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    endtask

    initial begin
        table_lo[0]  = 7'b1111111;
        table_lo[1]  = 7'b0001000;
        table_lo[2]  = 7'b0100100;
        table_lo[3]  = 7'b0110000;
        table_lo[4]  = 7'b0011001;
        table_lo[5]  = 7'b0010010;
        table_lo[6]  = 7'b0000010;
        table_lo[7]  = 7'b1111000;
        table_lo[8]  = 7'b0000000;
        table_lo[9]  = 7'b0010000;
        table_lo[10] = 7'b1000000;
        table_lo[11] = 7'b1100001;
        table_lo[12] = 7'b0011000;
        table_lo[13] = 7'b0001001;
        table_lo[14] = 7'b1111111;
        table_lo[15] = 7'b1111111;

        // Reset held for two edges with a card present
        #2;
        rst  = 1'b1;
        card = 4'd8;
        tick();
        check("reset_edge1", hex_lo, 7'b1111111);
        tick();
        check("reset_edge2", hex_lo, 7'b1111111);
        check("reset_inv", hex_hi, 7'b0000000);
        rst = 1'b0;
        tick();
        check("release_8", hex_lo, 7'b0000000);

        // Exhaustive sweep, both polarities
        for (int i = 0; i < 16; i++) begin
            card = 4'(i);
            tick();
            check($sformatf("sweep_%0d", i), hex_lo, table_lo[i]);
            check($sformatf("sweep_inv_%0d", i), hex_hi, ~table_lo[i]);
        end

        // Latency: change mid-cycle, output must wait for the edge
        card = 4'd2;
        tick();
        check("lat_2", hex_lo, 7'b0100100);
        @(negedge clk);
        card = 4'd3;
        #1;
        check("lat_hold", hex_lo, 7'b0100100);
        tick();
        check("lat_3", hex_lo, 7'b0110000);

        // Reset mid-stream
        card = 4'd12;
        tick();
        check("mid_q", hex_lo, 7'b0011000);
        rst = 1'b1;
        tick();
        check("mid_rst", hex_lo, 7'b1111111);
        check("mid_rst_inv", hex_hi, 7'b0000000);
        rst = 1'b0;
        tick();
        check("mid_release", hex_lo, 7'b0011000);

        // Inverted polarity Ace
        card = 4'd1;
        tick();
        check("inv_ace", hex_hi, 7'b1110111);
        check("lo_ace", hex_lo, 7'b0001000);

        // Unknown input followed by a known one
        card = 4'bxxxx;
        tick();
        card = 4'd7;
        tick();
        check("x_then_7", hex_lo, 7'b1111000);
        check("x_then_7_inv", hex_hi, 7'b0000111);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
